// File: rtl/pack_wb_sched.sv
// Write-back scheduler: round-robin arbitration over the PE result streams,
// int8 requantization, 4-byte packing and sequencing of packed words to the output SRAM.
module pack_wb_sched #(
   parameter int NUM_REQ = 4,
   parameter int IN_W    = 24,
   parameter int ADDR_W  = 10,
   parameter int CNT_W   = 16
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    start,
   input  logic                    abort,
   input  logic [ADDR_W-1:0]       cfg_base_addr,
   input  logic [CNT_W-1:0]        cfg_num_bytes,
   input  logic [4:0]              cfg_shift,
   input  logic [NUM_REQ-1:0]      req_valid,
   input  logic [NUM_REQ*IN_W-1:0] req_data,
   output logic [NUM_REQ-1:0]      req_ready,
   output logic                    wr_valid,
   output logic [ADDR_W-1:0]       wr_addr,
   output logic [31:0]             wr_data,
   output logic [3:0]              wr_mask,
   input  logic                    wr_ready,
   output logic                    busy,
   output logic                    done
);

   localparam int PTR_W = $clog2(NUM_REQ);
   localparam logic [CNT_W-1:0]  CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
   localparam logic [PTR_W-1:0]  PTR_ONE  = {{(PTR_W-1){1'b0}}, 1'b1};
   localparam logic [PTR_W-1:0]  PTR_LAST = PTR_W'(NUM_REQ - 1);
   localparam logic signed [IN_W-1:0] SAT_HI = {{(IN_W-8){1'b0}}, 8'h7F};
   localparam logic signed [IN_W-1:0] SAT_LO = {{(IN_W-8){1'b1}}, 8'h80};

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_DRAIN = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   function automatic logic [7:0] sat8(input logic signed [IN_W-1:0] v);
      logic [7:0] r;
      if (v > SAT_HI) begin
         r = 8'h7F;
      end else if (v < SAT_LO) begin
         r = 8'h80;
      end else begin
         r = v[7:0];
      end
      return r;
   endfunction

   state_t             state_q, state_d;
   logic [PTR_W-1:0]   ptr_q, ptr_d;
   logic [ADDR_W-1:0]  base_q, base_d;
   logic [CNT_W-1:0]   num_q, num_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [4:0]         shift_q, shift_d;
   logic [1:0]         lane_q, lane_d;
   logic [23:0]        buf_q, buf_d;
   logic [ADDR_W-1:0]  widx_q, widx_d;
   logic               wr_valid_q, wr_valid_d;
   logic [ADDR_W-1:0]  wr_addr_q, wr_addr_d;
   logic [31:0]        wr_data_q, wr_data_d;
   logic [3:0]         wr_mask_q, wr_mask_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;

   logic                   stall_s;
   logic [PTR_W-1:0]       gnt_idx_s;
   logic                   gnt_any_s;
   logic [NUM_REQ-1:0]     req_ready_s;
   logic                   acc_s;
   logic [IN_W-1:0]        sel_data_s;
   logic signed [IN_W-1:0] shifted_s;
   logic [7:0]             byte_s;
   logic                   last_s;
   logic                   word_end_s;
   logic [31:0]            cur_word_s;
   logic [3:0]             cur_mask_s;

   assign stall_s = wr_valid_q && !wr_ready;

   // Round-robin search starting at ptr_q, wrapping past the last PE.
   always_comb begin : arb
      int   idx;
      logic hit;
      gnt_idx_s = ptr_q;
      gnt_any_s = 1'b0;
      for (int k = 0; k < NUM_REQ; k++) begin
         idx       = int'(ptr_q) + k;
         idx       = (idx >= NUM_REQ) ? idx - NUM_REQ : idx;
         hit       = req_valid[idx] && !gnt_any_s;
         gnt_idx_s = hit ? PTR_W'(idx) : gnt_idx_s;
         gnt_any_s = gnt_any_s | req_valid[idx];
      end
   end

   // Accept at most one byte per cycle, only while running and not stalled.
   always_comb begin
      req_ready_s = '0;
      if ((state_q == S_RUN) && !stall_s && !abort && gnt_any_s) begin
         req_ready_s[gnt_idx_s] = 1'b1;
      end else begin
         req_ready_s = '0;
      end
   end

   assign acc_s      = |req_ready_s;
   assign sel_data_s = req_data[int'(gnt_idx_s)*IN_W +: IN_W];
   assign shifted_s  = $signed(sel_data_s) >>> shift_q;
   assign byte_s     = sat8(shifted_s);
   assign last_s     = ((cnt_q + CNT_ONE) == num_q);
   assign word_end_s = (lane_q == 2'd3) || last_s;
   assign cur_word_s = {8'h00, buf_q} | ({24'h000000, byte_s} << {lane_q, 3'b000});

   // Mask covers every lane filled up to and including the current one.
   always_comb begin
      case (lane_q)
         2'd0:    cur_mask_s = 4'b0001;
         2'd1:    cur_mask_s = 4'b0011;
         2'd2:    cur_mask_s = 4'b0111;
         2'd3:    cur_mask_s = 4'b1111;
         default: cur_mask_s = 4'b0000;
      endcase
   end

   // Job sequencing, packing and output word register next-state.
   always_comb begin
      state_d    = state_q;
      ptr_d      = ptr_q;
      base_d     = base_q;
      num_d      = num_q;
      shift_d    = shift_q;
      cnt_d      = cnt_q;
      lane_d     = lane_q;
      buf_d      = buf_q;
      widx_d     = widx_q;
      wr_addr_d  = wr_addr_q;
      wr_data_d  = wr_data_q;
      wr_mask_d  = wr_mask_q;
      wr_valid_d = (wr_valid_q && wr_ready) ? 1'b0 : wr_valid_q;
      done_d     = 1'b0;
      if (abort) begin
         state_d    = S_IDLE;
         wr_valid_d = 1'b0;
         lane_d     = 2'd0;
         buf_d      = 24'h000000;
      end else begin
         done_d = (state_q == S_DONE);
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  base_d  = cfg_base_addr;
                  num_d   = cfg_num_bytes;
                  shift_d = cfg_shift;
                  cnt_d   = '0;
                  lane_d  = 2'd0;
                  buf_d   = 24'h000000;
                  widx_d  = '0;
                  state_d = (cfg_num_bytes == '0) ? S_DONE : S_RUN;
               end else begin
                  state_d = S_IDLE;
               end
            end
            S_RUN: begin
               if (acc_s) begin
                  cnt_d = cnt_q + CNT_ONE;
                  ptr_d = (gnt_idx_s == PTR_LAST) ? '0 : gnt_idx_s + PTR_ONE;
                  if (word_end_s) begin
                     wr_valid_d = 1'b1;
                     wr_addr_d  = base_q + widx_q;
                     wr_data_d  = cur_word_s;
                     wr_mask_d  = cur_mask_s;
                     widx_d     = widx_q + ADDR_ONE;
                     lane_d     = 2'd0;
                     buf_d      = 24'h000000;
                  end else begin
                     buf_d  = buf_q | ({16'h0000, byte_s} << {lane_q, 3'b000});
                     lane_d = lane_q + 2'd1;
                  end
                  state_d = last_s ? S_DRAIN : S_RUN;
               end else begin
                  state_d = S_RUN;
               end
            end
            S_DRAIN: state_d = (wr_valid_q && wr_ready) ? S_DONE : S_DRAIN;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
         endcase
      end
      busy_d = (state_d != S_IDLE);
   end

   // State and output registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_IDLE;
         ptr_q      <= '0;
         base_q     <= '0;
         num_q      <= '0;
         shift_q    <= 5'd0;
         cnt_q      <= '0;
         lane_q     <= 2'd0;
         buf_q      <= 24'h000000;
         widx_q     <= '0;
         wr_valid_q <= 1'b0;
         wr_addr_q  <= '0;
         wr_data_q  <= 32'h00000000;
         wr_mask_q  <= 4'b0000;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         ptr_q      <= ptr_d;
         base_q     <= base_d;
         num_q      <= num_d;
         shift_q    <= shift_d;
         cnt_q      <= cnt_d;
         lane_q     <= lane_d;
         buf_q      <= buf_d;
         widx_q     <= widx_d;
         wr_valid_q <= wr_valid_d;
         wr_addr_q  <= wr_addr_d;
         wr_data_q  <= wr_data_d;
         wr_mask_q  <= wr_mask_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
      end
   end

   assign req_ready = req_ready_s;
   assign wr_valid  = wr_valid_q;
   assign wr_addr   = wr_addr_q;
   assign wr_data   = wr_data_q;
   assign wr_mask   = wr_mask_q;
   assign busy      = busy_q;
   assign done      = done_q;

endmodule
